// File: rtl/operand_scoreboard_if.sv
// operand_scoreboard_if
//   Bundles the ID-stage request, EX back-pressure, WB commit, flush and the
//   scoreboard's decision/status outputs.
//   master : drives the decoded instruction, ex_busy, WB commit and flush
//   slave  : the scoreboard; returns id_stall, id_issue, inflight, stall_cycles
interface operand_scoreboard_if #(
  parameter int CNT_W = 3
);
  logic             id_valid;
  logic             id_rs_read;
  logic             id_rt_read;
  logic [4:0]       id_rs_addr;
  logic [4:0]       id_rt_addr;
  logic             id_wb_en;
  logic [4:0]       id_wb_addr;
  logic             ex_busy;
  logic             wb_en;
  logic [4:0]       wb_addr;
  logic             flush;
  logic             id_stall;
  logic             id_issue;
  logic [CNT_W-1:0] inflight;
  logic [31:0]      stall_cycles;

  modport master (
    output id_valid, id_rs_read, id_rt_read, id_rs_addr, id_rt_addr,
           id_wb_en, id_wb_addr, ex_busy, wb_en, wb_addr, flush,
    input  id_stall, id_issue, inflight, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs_read, id_rt_read, id_rs_addr, id_rt_addr,
           id_wb_en, id_wb_addr, ex_busy, wb_en, wb_addr, flush,
    output id_stall, id_issue, inflight, stall_cycles
  );
endinterface

// File: rtl/operand_scoreboard.sv
// operand_scoreboard
//   Register-dependency scoreboard and issue controller for the ID stage.
//   Keeps a pending-write counter per GPR (r0 never pends), a total in-flight
//   counter capped at MAX_INFLIGHT, and a saturating stall-cycle counter.
//   Stall/issue are combinational from current state and inputs.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     sb       : operand_scoreboard_if.slave (ID request, ex_busy, WB commit,
//                flush in; id_stall, id_issue, inflight, stall_cycles out)
//   Parameters: MAX_INFLIGHT in 1..7, CNT_W with 2**CNT_W > MAX_INFLIGHT.
module operand_scoreboard #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  operand_scoreboard_if.slave   sb
);

  // Entry 0 is held at zero so r0 reads as always ready.
  logic [CNT_W-1:0] pend_q [32];
  logic [CNT_W-1:0] pend_d [32];
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [31:0]      stall_q, stall_d;

  logic rs_ok, rt_ok, hazard, full;
  logic wr_req, inc, dec;
  logic stall, issue;

  // A source pending exactly once whose write commits this cycle is ready:
  // the register file write and the operand read happen in the same cycle.
  always_comb begin
    rs_ok = !sb.id_rs_read || (sb.id_rs_addr == 5'd0) ||
            (pend_q[sb.id_rs_addr] == '0) ||
            ((pend_q[sb.id_rs_addr] == CNT_W'(1)) && sb.wb_en &&
             (sb.wb_addr == sb.id_rs_addr));
    rt_ok = !sb.id_rt_read || (sb.id_rt_addr == 5'd0) ||
            (pend_q[sb.id_rt_addr] == '0) ||
            ((pend_q[sb.id_rt_addr] == CNT_W'(1)) && sb.wb_en &&
             (sb.wb_addr == sb.id_rt_addr));
    hazard = !rs_ok || !rt_ok;
    wr_req = sb.id_wb_en && (sb.id_wb_addr != 5'd0);
    dec    = sb.wb_en && (sb.wb_addr != 5'd0);
    // A commit in the same cycle frees a slot, so a write may still issue.
    full   = (inflight_q == CNT_W'(MAX_INFLIGHT)) && wr_req && !dec;
    stall  = sb.id_valid && (hazard || sb.ex_busy || full) && !sb.flush;
    issue  = sb.id_valid && !stall && !sb.flush;
    inc    = issue && wr_req;
  end

  // Next state. Flush wipes everything younger than WB, including the
  // bookkeeping for this cycle's commit.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      pend_d[r] = pend_q[r];
      if (r == 0 || sb.flush) begin
        pend_d[r] = '0;
      end else begin
        if (inc && (sb.id_wb_addr == 5'(r)) &&
            !(dec && (sb.wb_addr == 5'(r)))) begin
          pend_d[r] = pend_q[r] + CNT_W'(1);
        end else if (dec && (sb.wb_addr == 5'(r)) &&
                     !(inc && (sb.id_wb_addr == 5'(r))) &&
                     (pend_q[r] != '0)) begin
          pend_d[r] = pend_q[r] - CNT_W'(1);
        end
      end
    end

    inflight_d = inflight_q;
    if (sb.flush) begin
      inflight_d = '0;
    end else if (inc && !dec) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (dec && !inc && (inflight_q != '0)) begin
      inflight_d = inflight_q - CNT_W'(1);
    end

    stall_d = stall_q;
    if (stall && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        pend_q[r] <= '0;
      end
      inflight_q <= '0;
      stall_q    <= '0;
    end else begin
      pend_q     <= pend_d;
      inflight_q <= inflight_d;
      stall_q    <= stall_d;
    end
  end

  assign sb.id_stall     = stall;
  assign sb.id_issue     = issue;
  assign sb.inflight     = inflight_q;
  assign sb.stall_cycles = stall_q;

  // A commit for a register with nothing pending means WB and ID disagree.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(dec && !sb.flush && (pend_q[sb.wb_addr] == '0)));

endmodule

// File: doc/operand_scoreboard.md
# operand_scoreboard

Register-dependency scoreboard and issue controller for the ID stage. It tracks which general-purpose registers have writes still in flight between issue and writeback, and holds the ID stage whenever an instruction's source operands are not yet valid in the register file. It also caps the total number of in-flight writes and keeps a saturating stall-cycle counter. It sits beside the ID-stage operand generator, gates the ID→EX pipeline register, and receives commit information from the WB stage.

## Interface
- `MAX_INFLIGHT`, default 3: maximum outstanding register writes, from 1 to 7.
- `CNT_W`, default 3: width of each per-register pending counter. Must satisfy 2^CNT_W > MAX_INFLIGHT.
- `clk`  in  1  — the only clock; everything is rising-edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `id_valid`  in  1  — the ID stage holds a valid decoded instruction.
- `id_rs_read` / `id_rt_read`  in  1 each  — the instruction reads rs / rt.
- `id_rs_addr` / `id_rt_addr`  in  5 each  — source register numbers.
- `id_wb_en`  in  1  — the instruction writes a register.
- `id_wb_addr`  in  5  — destination register number.
- `ex_busy`  in  1  — a multi-cycle EX unit cannot accept an instruction.
- `wb_en`  in  1  — WB commits a register write this cycle.
- `wb_addr`  in  5  — register number being committed.
- `flush`  in  1  — kill every instruction younger than WB.
- `id_stall`  out  1  — hold the IF/ID registers.
- `id_issue`  out  1  — the ID→EX register captures this cycle.
- `inflight`  out  CNT_W  — total outstanding writes.
- `stall_cycles`  out  32  — saturating count of cycles with `id_stall` high.

## Operation
- State:
  - `pend[1..31]`: one CNT_W-bit counter per register. Register 0 has no counter and is always ready.
  - `inflight`: one CNT_W-bit counter for the total.
- Source readiness: a source is ready if it is not read, or its address is 0, or `pend[addr]` is 0.
  - Same-cycle WB bypass: a source is also ready when `pend[addr]` is 1, `wb_en` is high and `wb_addr` equals `addr`.
- Combinational outputs:
  - `hazard` = (rs not ready) | (rt not ready).
  - `full` = `inflight` == MAX_INFLIGHT, AND (`id_wb_en` & `id_wb_addr` != 0), AND NOT (`wb_en` & `wb_addr` != 0).
  - `id_stall` = `id_valid` & (`hazard` | `ex_busy` | `full`) & !`flush`.
  - `id_issue` = `id_valid` & !`id_stall` & !`flush`.
- Counter update at each edge, with inc = `id_issue` & `id_wb_en` & `id_wb_addr` != 0, and dec = `wb_en` & `wb_addr` != 0:
  - `pend[id_wb_addr]` increments on inc; `pend[wb_addr]` decrements on dec.
  - When inc and dec hit the same register, that counter is unchanged.
  - `inflight` changes by (+inc − dec).
- Underflow is a protocol error: a decrement at 0 leaves the counter at 0. An assertion flags it in simulation.
- Flush:
  - Clears every `pend` and `inflight` to 0 on the next edge.
  - A `wb_en` in the same cycle is ignored, because WB is older than the flush point and its register file write still happens.
  - `id_issue` and `id_stall` are forced to 0 during the flush cycle.
- `stall_cycles` increments on each edge where `id_stall` is 1. It saturates at 0xFFFF_FFFF and is cleared only by reset, not by flush.

## Timing
- Reset (asynchronous, immediate): all `pend` = 0, `inflight` = 0, `stall_cycles` = 0. `id_stall` and `id_issue` then follow the inputs combinationally.
- All outputs except the counters are combinational from the current state and inputs. The decision is in the same cycle; there is zero latency to stall.
- A register written by an instruction issued at cycle t is pending from t+1 until the edge after its WB commit. Dependents can issue in the WB commit cycle itself, through the bypass.
- A load-use pair, or any back-to-back dependency, stalls until the producer reaches WB. There is no EX/MEM forwarding here.
- Reset asserted mid-operation discards all pending state. The first instruction after release issues if `ex_busy` = 0.

## Test plan
- **Reset and idle.** Assert `rst` with random inputs, then release. Required: `inflight` = 0, `stall_cycles` = 0. An instruction with `id_valid` = 1 reading r5/r6 gets `id_issue` = 1 and `id_stall` = 0.
- **RAW with bypass.** Issue a write to r3 at cycle 0, then a reader of r3 at cycle 1. Required: `id_stall` = 1 until the cycle `wb_en` = 1 with `wb_addr` = 3. `id_issue` = 1 in that same cycle. `stall_cycles` equals the stalled cycles.
- **r0 and double write.** A write to r0 leaves `inflight` at 0 and never stalls readers of r0. Two writes to r7 give `pend[7]` = 2. After the first WB of r7, a reader of r7 still stalls; after the second WB, it issues.
- **Full.** With MAX_INFLIGHT = 3, issue three writes to r1, r2, r4. A fourth write to r8 requires `id_stall` = 1. A cycle with `wb_en` to r1 lets it issue, and `inflight` stays 3.
- **Simultaneous inc/dec and ex_busy.** Issue a write to r9 while WB commits r9 with `pend[9]` = 1. Required: `pend[9]` stays 1. Raising `ex_busy` stalls an independent instruction for exactly that many cycles.
- **Flush.** With r2 and r3 pending, assert `flush` together with `wb_en` to r2. Required: `id_issue` = 0 that cycle. On the next cycle, `inflight` = 0 and readers of r2/r3 issue immediately. `stall_cycles` is unchanged.
